// File: rtl/dither_pkg.sv
// Shared types, Floyd-Steinberg weights and pixel helpers for the dithering pipeline.
package dither_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH1 = 2'd2,
        FLUSH2 = 2'd3
    } dither_state_t;

    localparam int PIX_W       = 8;
    localparam int ERR_W       = 9;
    localparam int HCOUNT_W    = 11;
    localparam int VCOUNT_W    = 10;

    // Error diffusion weights, in sixteenths.
    localparam int W_RIGHT       = 7;
    localparam int W_BELOW_LEFT  = 3;
    localparam int W_BELOW       = 5;
    localparam int W_BELOW_RIGHT = 1;
    localparam int SHARE_SHIFT   = 4;

    localparam int SHARE_PROD_W  = ERR_W + 4;

    // Add a signed error share to an unsigned pixel and clamp to 0..255.
    function automatic logic [PIX_W-1:0] sat_add(
        input logic [PIX_W-1:0]        pix,
        input logic signed [ERR_W-1:0] share
    );
        logic signed [ERR_W+1:0] sum;
        sum = $signed({3'b000, pix}) + $signed({{2{share[ERR_W-1]}}, share});
        if (sum < 0) begin
            return '0;
        end else if (sum > 11'sd255) begin
            return '1;
        end else begin
            return sum[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fs_error_split.sv
// Combinational split of a quantization error into the four weighted shares,
// each rounded toward minus infinity.
module fs_error_split
    import dither_pkg::*;
(
    input  logic signed [ERR_W-1:0] err,
    output logic signed [ERR_W-1:0] s7,
    output logic signed [ERR_W-1:0] s3,
    output logic signed [ERR_W-1:0] s5,
    output logic signed [ERR_W-1:0] s1
);

    localparam int WEIGHTS [4] = '{W_RIGHT, W_BELOW_LEFT, W_BELOW, W_BELOW_RIGHT};

    logic signed [ERR_W-1:0] share [4];

    function automatic logic signed [ERR_W-1:0] weighted_share(
        input logic signed [ERR_W-1:0] e,
        input int                      k
    );
        logic signed [SHARE_PROD_W-1:0] prod;
        logic signed [SHARE_PROD_W-1:0] shifted;
        // |e*k| never exceeds 255*7, so the widened product cannot wrap.
        prod    = $signed({{(SHARE_PROD_W-ERR_W){e[ERR_W-1]}}, e}) * $signed(SHARE_PROD_W'(k));
        shifted = prod >>> SHARE_SHIFT;
        return shifted[ERR_W-1:0];
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_share
            assign share[gi] = weighted_share(err, WEIGHTS[gi]);
        end
    endgenerate

    assign s7 = share[0];
    assign s3 = share[1];
    assign s5 = share[2];
    assign s1 = share[3];

endmodule

// File: rtl/fs_dither.sv
// Streaming Floyd-Steinberg ditherer: quantizes the current row to 1 bit and
// writes the error-adjusted next-row pixels back to an external line buffer.
module fs_dither
    import dither_pkg::*;
#(
    parameter int FRAME_WIDTH  = 240,
    parameter int FRAME_HEIGHT = 240,
    parameter int THRESHOLD    = 128
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                in_valid,
    input  logic [HCOUNT_W-1:0] in_hcount,
    input  logic [VCOUNT_W-1:0] in_vcount,
    input  logic [PIX_W-1:0]    in_b,
    input  logic [PIX_W-1:0]    in_e,
    output logic                out_valid,
    output logic                out_bit,
    output logic [HCOUNT_W-1:0] out_hcount,
    output logic [VCOUNT_W-1:0] out_vcount,
    output logic                wb_valid,
    output logic [PIX_W-1:0]    wb_pixel,
    output logic [HCOUNT_W-1:0] wb_hcount,
    output logic                err_overrun
);

    localparam logic [HCOUNT_W-1:0] LAST_COL = HCOUNT_W'(FRAME_WIDTH - 1);
    localparam logic [HCOUNT_W-1:0] PREV_COL = HCOUNT_W'(FRAME_WIDTH - 2);
    localparam logic [VCOUNT_W-1:0] LAST_ROW = VCOUNT_W'(FRAME_HEIGHT - 1);

    dither_state_t       state_q, state_d;
    logic [PIX_W-1:0]    a_q, a_d;
    logic [PIX_W-1:0]    dl_q, dl_d;
    logic [PIX_W-1:0]    dm_q, dm_d;
    logic [VCOUNT_W-1:0] row_q, row_d;

    logic                out_valid_q, out_valid_d;
    logic                out_bit_q, out_bit_d;
    logic [HCOUNT_W-1:0] out_hcount_q, out_hcount_d;
    logic [VCOUNT_W-1:0] out_vcount_q, out_vcount_d;
    logic                wb_valid_q, wb_valid_d;
    logic [PIX_W-1:0]    wb_pixel_q, wb_pixel_d;
    logic [HCOUNT_W-1:0] wb_hcount_q, wb_hcount_d;
    logic                err_overrun_q, err_overrun_d;

    logic                    q_bit;
    logic signed [ERR_W-1:0] q_err;
    logic signed [ERR_W-1:0] s7, s3, s5, s1;

    // A is always the pixel being quantized, whether in RUN or FLUSH1.
    assign q_bit = int'(a_q) >= THRESHOLD;
    assign q_err = $signed({1'b0, a_q}) - (q_bit ? 9'sd255 : 9'sd0);

    fs_error_split u_split (
        .err (q_err),
        .s7  (s7),
        .s3  (s3),
        .s5  (s5),
        .s1  (s1)
    );

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        dl_d          = dl_q;
        dm_d          = dm_q;
        row_d         = row_q;
        out_valid_d   = 1'b0;
        out_bit_d     = out_bit_q;
        out_hcount_d  = out_hcount_q;
        out_vcount_d  = out_vcount_q;
        wb_valid_d    = 1'b0;
        wb_pixel_d    = wb_pixel_q;
        wb_hcount_d   = wb_hcount_q;
        err_overrun_d = err_overrun_q;

        case (state_q)
            FLUSH1: begin
                // Last column: right and below-right neighbours fall off the row.
                out_valid_d  = 1'b1;
                out_bit_d    = q_bit;
                out_hcount_d = LAST_COL;
                out_vcount_d = row_q;
                wb_valid_d   = (row_q != LAST_ROW);
                if (wb_valid_d) begin
                    wb_pixel_d  = sat_add(dl_q, s3);
                    wb_hcount_d = PREV_COL;
                end
                dm_d    = sat_add(dm_q, s5);
                state_d = FLUSH2;
                if (in_valid) begin
                    err_overrun_d = 1'b1;
                end
            end

            FLUSH2: begin
                wb_valid_d = (row_q != LAST_ROW);
                if (wb_valid_d) begin
                    wb_pixel_d  = dm_q;
                    wb_hcount_d = LAST_COL;
                end
                state_d = IDLE;
                if (in_valid) begin
                    err_overrun_d = 1'b1;
                end
            end

            default: begin
                if (in_valid && (in_hcount == '0)) begin
                    // Row start; any partially processed row is dropped here.
                    a_d     = in_b;
                    dm_d    = in_e;
                    dl_d    = '0;
                    row_d   = in_vcount;
                    state_d = RUN;
                end else if (in_valid && (state_q == RUN)) begin
                    out_valid_d  = 1'b1;
                    out_bit_d    = q_bit;
                    out_hcount_d = in_hcount - 11'd1;
                    out_vcount_d = in_vcount;
                    wb_valid_d   = (in_hcount != 11'd1) && (in_vcount != LAST_ROW);
                    if (wb_valid_d) begin
                        wb_pixel_d  = sat_add(dl_q, s3);
                        wb_hcount_d = in_hcount - 11'd2;
                    end
                    a_d   = sat_add(in_b, s7);
                    dl_d  = sat_add(dm_q, s5);
                    dm_d  = sat_add(in_e, s1);
                    row_d = in_vcount;
                    if (in_hcount == LAST_COL) begin
                        state_d = FLUSH1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            a_q           <= '0;
            dl_q          <= '0;
            dm_q          <= '0;
            row_q         <= '0;
            out_valid_q   <= 1'b0;
            out_bit_q     <= 1'b0;
            out_hcount_q  <= '0;
            out_vcount_q  <= '0;
            wb_valid_q    <= 1'b0;
            wb_pixel_q    <= '0;
            wb_hcount_q   <= '0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            dl_q          <= dl_d;
            dm_q          <= dm_d;
            row_q         <= row_d;
            out_valid_q   <= out_valid_d;
            out_bit_q     <= out_bit_d;
            out_hcount_q  <= out_hcount_d;
            out_vcount_q  <= out_vcount_d;
            wb_valid_q    <= wb_valid_d;
            wb_pixel_q    <= wb_pixel_d;
            wb_hcount_q   <= wb_hcount_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_bit     = out_bit_q;
    assign out_hcount  = out_hcount_q;
    assign out_vcount  = out_vcount_q;
    assign wb_valid    = wb_valid_q;
    assign wb_pixel    = wb_pixel_q;
    assign wb_hcount   = wb_hcount_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_fs_dither.sv
// Directed bench for fs_dither on a 6x4 frame with hand-computed expectations.
module tb_fs_dither;

    localparam int W = 6;
    localparam int H = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        in_valid = 1'b0;
    logic [10:0] in_hcount = '0;
    logic [9:0]  in_vcount = '0;
    logic [7:0]  in_b = '0;
    logic [7:0]  in_e = '0;
    logic        out_valid;
    logic        out_bit;
    logic [10:0] out_hcount;
    logic [9:0]  out_vcount;
    logic        wb_valid;
    logic [7:0]  wb_pixel;
    logic [10:0] wb_hcount;
    logic        err_overrun;

    int total = 0;
    int bad   = 0;

    fs_dither #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .THRESHOLD    (128)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .in_valid    (in_valid),
        .in_hcount   (in_hcount),
        .in_vcount   (in_vcount),
        .in_b        (in_b),
        .in_e        (in_e),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
        .out_hcount  (out_hcount),
        .out_vcount  (out_vcount),
        .wb_valid    (wb_valid),
        .wb_pixel    (wb_pixel),
        .wb_hcount   (wb_hcount),
        .err_overrun (err_overrun)
    );

    always #5 clk_in = ~clk_in;

    // One input cycle; outputs registered from it are visible on return.
    task automatic drive(input logic v, input logic [10:0] h, input logic [9:0] vc,
                         input logic [7:0] b, input logic [7:0] e);
        @(negedge clk_in);
        in_valid  = v;
        in_hcount = h;
        in_vcount = vc;
        in_b      = b;
        in_e      = e;
        @(posedge clk_in);
        #1;
        $display("txn in_v=%0b h=%0d v=%0d b=%0d e=%0d | ov=%0b bit=%0b oh=%0d ovc=%0d | wv=%0b wp=%0d wh=%0d ovr=%0b",
                 v, h, vc, b, e, out_valid, out_bit, out_hcount, out_vcount,
                 wb_valid, wb_pixel, wb_hcount, err_overrun);
    endtask

    task automatic test_reset();
        drive(1'b0, 11'd0, 10'd0, 8'd0, 8'd0);
        total++;
        if ({out_valid, out_bit, out_hcount, out_vcount, wb_valid, wb_pixel, wb_hcount, err_overrun} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_valid, out_bit, out_hcount, out_vcount, wb_valid, wb_pixel, wb_hcount, err_overrun});
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        drive(1'b0, 11'd0, 10'd0, 8'd0, 8'd0);
        total++;
        if ({out_valid, wb_valid, err_overrun} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release_idle: got %b expected 000", {out_valid, wb_valid, err_overrun});
        end
    endtask

    // Row of constant pixels: error is the same every column, so every write-back is exp_wb.
    task automatic test_uniform_row(input string name, input logic [9:0] vc, input logic [7:0] b,
                                    input logic [7:0] e, input logic exp_bit, input logic [7:0] exp_wb,
                                    input logic wb_en);
        logic exp_ov;
        logic exp_wv;
        for (int h = 0; h < W; h++) begin
            drive(1'b1, 11'(h), vc, b, e);
            exp_ov = (h >= 1);
            exp_wv = (h >= 2) && wb_en;
            total++;
            if ({out_valid, wb_valid} !== {exp_ov, exp_wv}) begin
                bad++;
                $display("FAIL %s_valids h=%0d: got %b expected %b", name, h, {out_valid, wb_valid}, {exp_ov, exp_wv});
            end
            if (exp_ov) begin
                total++;
                if ({out_bit, out_hcount, out_vcount} !== {exp_bit, 11'(h - 1), vc}) begin
                    bad++;
                    $display("FAIL %s_out h=%0d: got bit=%0b col=%0d row=%0d expected bit=%0b col=%0d row=%0d",
                             name, h, out_bit, out_hcount, out_vcount, exp_bit, h - 1, vc);
                end
            end
            if (exp_wv) begin
                total++;
                if ({wb_pixel, wb_hcount} !== {exp_wb, 11'(h - 2)}) begin
                    bad++;
                    $display("FAIL %s_wb h=%0d: got pix=%0d col=%0d expected pix=%0d col=%0d",
                             name, h, wb_pixel, wb_hcount, exp_wb, h - 2);
                end
            end
        end
        drive(1'b0, 11'd0, vc, 8'd0, 8'd0);
        total++;
        if ({out_valid, out_bit, out_hcount, out_vcount, wb_valid} !== {1'b1, exp_bit, 11'(W - 1), vc, wb_en}) begin
            bad++;
            $display("FAIL %s_flush1: got ov=%0b bit=%0b col=%0d row=%0d wv=%0b expected 1 %0b %0d %0d %0b",
                     name, out_valid, out_bit, out_hcount, out_vcount, wb_valid, exp_bit, W - 1, vc, wb_en);
        end
        if (wb_en) begin
            total++;
            if ({wb_pixel, wb_hcount} !== {exp_wb, 11'(W - 2)}) begin
                bad++;
                $display("FAIL %s_flush1_wb: got pix=%0d col=%0d expected pix=%0d col=%0d",
                         name, wb_pixel, wb_hcount, exp_wb, W - 2);
            end
        end
        drive(1'b0, 11'd0, vc, 8'd0, 8'd0);
        total++;
        if ({out_valid, wb_valid} !== {1'b0, wb_en}) begin
            bad++;
            $display("FAIL %s_flush2_valids: got %b expected %b", name, {out_valid, wb_valid}, {1'b0, wb_en});
        end
        if (wb_en) begin
            total++;
            if ({wb_pixel, wb_hcount} !== {exp_wb, 11'(W - 1)}) begin
                bad++;
                $display("FAIL %s_flush2_wb: got pix=%0d col=%0d expected pix=%0d col=%0d",
                         name, wb_pixel, wb_hcount, exp_wb, W - 1);
            end
        end
        drive(1'b0, 11'd0, vc, 8'd0, 8'd0);
        total++;
        if ({out_valid, wb_valid} !== 2'b00) begin
            bad++;
            $display("FAIL %s_idle: got %b expected 00", name, {out_valid, wb_valid});
        end
    endtask

    // Impulse of 100 at column 0: shares 43/18/31/6, then 18/8/13/2 from A=43.
    task automatic test_impulse();
        logic [7:0] exp_wb [3] = '{8'd39, 8'd22, 8'd8};
        drive(1'b1, 11'd0, 10'd2, 8'd100, 8'd0);
        total++;
        if ({out_valid, wb_valid} !== 2'b00) begin
            bad++;
            $display("FAIL impulse_col0_load: got %b expected 00", {out_valid, wb_valid});
        end
        drive(1'b1, 11'd1, 10'd2, 8'd0, 8'd0);
        total++;
        if ({out_valid, out_bit, out_hcount, wb_valid} !== {1'b1, 1'b0, 11'd0, 1'b0}) begin
            bad++;
            $display("FAIL impulse_col0_out: got ov=%0b bit=%0b col=%0d wv=%0b expected 1 0 0 0",
                     out_valid, out_bit, out_hcount, wb_valid);
        end
        for (int h = 2; h < 5; h++) begin
            drive(1'b1, 11'(h), 10'd2, 8'd0, 8'd0);
            total++;
            if ({out_bit, wb_valid, wb_pixel, wb_hcount} !== {1'b0, 1'b1, exp_wb[h - 2], 11'(h - 2)}) begin
                bad++;
                $display("FAIL impulse_wb h=%0d: got bit=%0b wv=%0b pix=%0d col=%0d expected 0 1 %0d %0d",
                         h, out_bit, wb_valid, wb_pixel, wb_hcount, exp_wb[h - 2], h - 2);
            end
        end
        drive(1'b1, 11'd5, 10'd2, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 11'd0, 10'd2, 8'd0, 8'd0);
    endtask

    // A=200 gives err=-55; floor shares -25/-11/-18/-4 differ from truncation.
    task automatic test_negative_error();
        drive(1'b1, 11'd0, 10'd2, 8'd200, 8'd50);
        drive(1'b1, 11'd1, 10'd2, 8'd100, 8'd100);
        total++;
        if ({out_valid, out_bit, out_hcount, wb_valid} !== {1'b1, 1'b1, 11'd0, 1'b0}) begin
            bad++;
            $display("FAIL neg_col0_out: got ov=%0b bit=%0b col=%0d wv=%0b expected 1 1 0 0",
                     out_valid, out_bit, out_hcount, wb_valid);
        end
        drive(1'b1, 11'd2, 10'd2, 8'd0, 8'd0);
        total++;
        if ({out_bit, wb_valid, wb_pixel, wb_hcount} !== {1'b0, 1'b1, 8'd46, 11'd0}) begin
            bad++;
            $display("FAIL neg_wb_col0: got bit=%0b wv=%0b pix=%0d col=%0d expected 0 1 46 0",
                     out_bit, wb_valid, wb_pixel, wb_hcount);
        end
        drive(1'b1, 11'd3, 10'd2, 8'd0, 8'd0);
        total++;
        if ({wb_valid, wb_pixel, wb_hcount} !== {1'b1, 8'd125, 11'd1}) begin
            bad++;
            $display("FAIL neg_wb_col1: got wv=%0b pix=%0d col=%0d expected 1 125 1", wb_valid, wb_pixel, wb_hcount);
        end
    endtask

    // Starts mid-row (restart), then A=127 over DM=250: DL = 250+39 clamps to 255.
    task automatic test_saturation();
        drive(1'b1, 11'd0, 10'd1, 8'd127, 8'd250);
        total++;
        if ({out_valid, wb_valid} !== 2'b00) begin
            bad++;
            $display("FAIL restart_no_flush: got %b expected 00", {out_valid, wb_valid});
        end
        drive(1'b1, 11'd1, 10'd1, 8'd0, 8'd0);
        total++;
        if ({out_valid, out_bit, out_hcount, out_vcount, wb_valid} !== {1'b1, 1'b0, 11'd0, 10'd1, 1'b0}) begin
            bad++;
            $display("FAIL sat_col0_out: got ov=%0b bit=%0b col=%0d row=%0d wv=%0b expected 1 0 0 1 0",
                     out_valid, out_bit, out_hcount, out_vcount, wb_valid);
        end
        drive(1'b1, 11'd2, 10'd1, 8'd0, 8'd0);
        total++;
        if ({wb_valid, wb_pixel, wb_hcount} !== {1'b1, 8'd255, 11'd0}) begin
            bad++;
            $display("FAIL sat_below: got wv=%0b pix=%0d col=%0d expected 1 255 0", wb_valid, wb_pixel, wb_hcount);
        end
        for (int h = 3; h < W; h++) drive(1'b1, 11'(h), 10'd1, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 11'd0, 10'd1, 8'd0, 8'd0);
    endtask

    task automatic test_overrun();
        for (int h = 0; h < W; h++) drive(1'b1, 11'(h), 10'd0, 8'd255, 8'd200);
        total++;
        if (err_overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_before: got %0b expected 0", err_overrun);
        end
        drive(1'b1, 11'd0, 10'd0, 8'd0, 8'd0);
        total++;
        if ({out_valid, out_bit, out_hcount, wb_valid, wb_pixel, wb_hcount, err_overrun} !==
            {1'b1, 1'b1, 11'(W - 1), 1'b1, 8'd200, 11'(W - 2), 1'b1}) begin
            bad++;
            $display("FAIL overrun_flush1: got ov=%0b bit=%0b col=%0d wv=%0b pix=%0d wcol=%0d ovr=%0b expected 1 1 %0d 1 200 %0d 1",
                     out_valid, out_bit, out_hcount, wb_valid, wb_pixel, wb_hcount, err_overrun, W - 1, W - 2);
        end
        drive(1'b1, 11'd0, 10'd0, 8'd0, 8'd0);
        total++;
        if ({out_valid, wb_valid, wb_pixel, wb_hcount, err_overrun} !== {1'b0, 1'b1, 8'd200, 11'(W - 1), 1'b1}) begin
            bad++;
            $display("FAIL overrun_flush2: got ov=%0b wv=%0b pix=%0d col=%0d ovr=%0b expected 0 1 200 %0d 1",
                     out_valid, wb_valid, wb_pixel, wb_hcount, err_overrun, W - 1);
        end
        drive(1'b1, 11'd1, 10'd0, 8'd0, 8'd0);
        total++;
        if ({out_valid, wb_valid, err_overrun} !== 3'b001) begin
            bad++;
            $display("FAIL overrun_ignored_input: got %b expected 001", {out_valid, wb_valid, err_overrun});
        end
        drive(1'b0, 11'd0, 10'd0, 8'd0, 8'd0);
    endtask

    task automatic test_reset_midrow();
        for (int h = 0; h < 3; h++) drive(1'b1, 11'(h), 10'd1, 8'd255, 8'd200);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        total++;
        if ({out_valid, out_bit, out_hcount, out_vcount, wb_valid, wb_pixel, wb_hcount, err_overrun} !== '0) begin
            bad++;
            $display("FAIL midrow_reset_async: got %h expected 0",
                     {out_valid, out_bit, out_hcount, out_vcount, wb_valid, wb_pixel, wb_hcount, err_overrun});
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        drive(1'b1, 11'd3, 10'd1, 8'd255, 8'd200);
        total++;
        if ({out_valid, wb_valid} !== 2'b00) begin
            bad++;
            $display("FAIL midrow_reset_no_resume: got %b expected 00", {out_valid, wb_valid});
        end
        drive(1'b0, 11'd0, 10'd1, 8'd0, 8'd0);
        total++;
        if ({out_valid, wb_valid} !== 2'b00) begin
            bad++;
            $display("FAIL midrow_reset_no_flush: got %b expected 00", {out_valid, wb_valid});
        end
        test_uniform_row("after_reset", 10'd1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_uniform_row("zero_row", 10'd0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        test_uniform_row("white_row", 10'd1, 8'd255, 8'd200, 1'b1, 8'd200, 1'b1);
        test_impulse();
        test_negative_error();
        test_saturation();
        test_overrun();
        test_uniform_row("last_row", 10'(H - 1), 8'd255, 8'd200, 1'b1, 8'd200, 1'b0);
        test_reset_midrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fs_dither.md
FS_DITHER -- requirements
Module: fs_dither

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 240, pixels per row.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 240, rows per frame.
REQ-003 SHALL have parameter THRESHOLD, default 128, quantization threshold.
REQ-004 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports in_valid  input  1; in_hcount  input  11; in_vcount  input  10. These carry the line-buffer stream strobe and the column/row of the in_b and in_e pixels.
REQ-007 SHALL have ports in_b  input  8, current-row pixel at in_hcount; in_e  input  8, next-row pixel at in_hcount.
REQ-008 SHALL have ports out_valid  output  1; out_bit  output  1; out_hcount  output  11; out_vcount  output  10. These carry the quantized pixel and its coordinates.
REQ-009 SHALL have ports wb_valid  output  1; wb_pixel  output  8; wb_hcount  output  11. These carry the finished next-row pixel written back to the line buffer.
REQ-010 SHALL have port err_overrun  output  1, sticky flag for an input arriving during flush.

Function
REQ-011 SHALL hold window registers: A (current row, column h-1), DL (next row, h-2) and DM (next row, h-1). All values are clamped 8-bit.
REQ-012 SHALL, on in_valid with in_hcount==0, load A=in_b, DM=in_e and DL=0, and emit no output (state RUN). This applies mid-row as well, abandoning the partial row without a flush.
REQ-013 SHALL, on in_valid with in_hcount=h>=1 in RUN, quantize A as follows: bit=(A>=THRESHOLD); err=A-(bit?255:0), signed 9-bit.
REQ-014 SHALL compute the error shares as (err*k)>>>4, arithmetic (floor), for k=7 (right), 3 (below-left), 5 (below) and 1 (below-right).
REQ-015 SHALL, in the same cycle, update A<=sat(in_b+s7), DL<=sat(DM+s5) and DM<=sat(in_e+s1). sat() clamps to 0..255.
REQ-016 SHALL register outputs one cycle after the triggering input: out_valid=1, out_bit=bit, out_hcount=h-1, out_vcount=in_vcount; wb_valid=1, wb_pixel=sat(DL+s3), wb_hcount=h-2.
REQ-017 SHALL suppress wb_valid when h==1, because column -1 does not exist; s3 is discarded in that case.
REQ-018 SHALL, after in_hcount==FRAME_WIDTH-1, enter FLUSH1. In FLUSH1 it quantizes A (column W-1), discards s7 and s1, writes column W-2 with sat(DL+s3), and sets DM<=sat(DM+s5).
REQ-019 SHALL, in FLUSH2, write column W-1 with DM and no quantization, then return to IDLE.
REQ-020 SHALL require at least 2 idle input cycles after column W-1. An in_valid during FLUSH1/FLUSH2 is ignored and sets err_overrun=1.
REQ-021 SHALL suppress all wb_valid on row in_vcount==FRAME_HEIGHT-1; out_valid is unaffected.
REQ-022 SHALL hold outputs low (valid strobes) when in_valid=0 outside the flush states. Coordinate and data outputs hold their last value.
REQ-023 SHALL use FSM states IDLE, RUN, FLUSH1 and FLUSH2, with transitions:
  - IDLE->RUN on in_valid with hcount 0;
  - RUN->FLUSH1 after hcount W-1;
  - FLUSH1->FLUSH2;
  - FLUSH2->IDLE.

Reset
REQ-024 SHALL, on rst_in assertion (asynchronous), force state=IDLE, A=DL=DM=0 and all outputs 0, including err_overrun.
REQ-025 SHALL, on reset mid-row or mid-flush, produce no further wb or out strobes until the next hcount-0 input.

Structure
REQ-026 SHALL place the FSM state enum, the weight constants 7/3/5/1 and the share shift 4 in shared package dither_pkg. FRAME_WIDTH, FRAME_HEIGHT and THRESHOLD remain parameters.
REQ-027 SHALL instantiate one combinational sub-module, fs_error_split (err in; s7, s3, s5, s1 out), and no RAM.

Verification
REQ-028 SHALL cover the following scenario. Stimulus: a row with all in_b=0 and in_e=0. Response: out_bit=0 for every column and wb_pixel=0 for columns 0..W-1.
REQ-029 SHALL cover the following scenario. Stimulus: all in_b=255 and in_e=200. Response: out_bit=1 everywhere and wb_pixel=200 everywhere, since err=0.
REQ-030 SHALL cover the following scenario. Stimulus: column 0 in_b=100, all other in_b and in_e 0. Responses:
  - column 0 out_bit=0;
  - column 1 A=43;
  - wb at hcount 0 equals 39 (31+8).
REQ-031 SHALL cover the following scenario. Stimulus: A=127 with the below pixel in_e=250. Response: the below value saturates to 255, not 289.
REQ-032 SHALL cover the following scenario. Stimulus: in_valid asserted the cycle after column W-1. Response: the input is ignored, err_overrun=1, and the flush writes for columns W-2 and W-1 still occur.
REQ-033 SHALL cover the following scenario. Stimulus: rst_in pulsed mid-row, then a new hcount-0 row. Response: outputs are 0 immediately and there is no stale write-back.
